// File: rtl/if_id_pipe.sv
// if_id_pipe: IF/ID pipeline register with load-use hazard detection, branch flush and event counters
//   clk, rst            : clock, async active-high reset
//   instruction_in/pc_plus_4_in : fetched instruction and its PC+4
//   select_pc           : branch taken, flushes the slot
//   id_ex_mem_read/id_ex_rt     : load currently in EX and its destination
//   instruction_out/pc_plus_4_out/valid_out : registered slot presented to decode
//   pc_write/id_ex_bubble       : stall controls back to fetch and forward to ID/EX
//   stall_count/flush_count     : saturating event counters
module if_id_pipe #(
    parameter logic [31:0] NOP_WORD = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instruction_in,
    input  logic [31:0]      pc_plus_4_in,
    input  logic             select_pc,
    input  logic             id_ex_mem_read,
    input  logic [4:0]       id_ex_rt,
    output logic [31:0]      instruction_out,
    output logic [31:0]      pc_plus_4_out,
    output logic             valid_out,
    output logic             pc_write,
    output logic             id_ex_bubble,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);
    logic [5:0] opcode;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       rt_src;
    logic       hazard;
    assign opcode = instruction_out[31:26];
    assign rs     = instruction_out[25:21];
    assign rt     = instruction_out[20:16];
    // R-type, sw, beq and bne read rt; everything else writes it
    assign rt_src = opcode == 6'h00 || opcode == 6'h2B || opcode == 6'h04 || opcode == 6'h05;
    // gated by valid_out, so a flushed or reset slot can never stall
    assign hazard = valid_out && id_ex_mem_read && id_ex_rt != 5'd0 &&
                    (id_ex_rt == rs || (rt_src && id_ex_rt == rt));
    assign pc_write     = !hazard;
    assign id_ex_bubble = hazard;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instruction_out <= NOP_WORD;
            pc_plus_4_out   <= 32'd0;
            valid_out       <= 1'b0;
            stall_count     <= '0;
            flush_count     <= '0;
        end else if (select_pc) begin
            instruction_out <= NOP_WORD;
            pc_plus_4_out   <= 32'd0;
            valid_out       <= 1'b0;
            flush_count     <= flush_count + {{(CNT_W-1){1'b0}}, ~&flush_count};
        end else if (hazard) begin
            stall_count     <= stall_count + {{(CNT_W-1){1'b0}}, ~&stall_count};
        end else begin
            instruction_out <= instruction_in;
            pc_plus_4_out   <= pc_plus_4_in;
            valid_out       <= 1'b1;
        end
    end
endmodule

// File: tb/tb_if_id_pipe.sv
// tb_if_id_pipe: directed self-checking bench for if_id_pipe (CNT_W=4 to reach saturation quickly)
module tb_if_id_pipe;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instruction_in;
    logic [31:0] pc_plus_4_in;
    logic        select_pc;
    logic        id_ex_mem_read;
    logic [4:0]  id_ex_rt;
    logic [31:0] instruction_out;
    logic [31:0] pc_plus_4_out;
    logic        valid_out;
    logic        pc_write;
    logic        id_ex_bubble;
    logic [3:0]  stall_count;
    logic [3:0]  flush_count;
    int          tests = 0;
    int          failed = 0;

    if_id_pipe #(.NOP_WORD(32'h0000_0000), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .instruction_in(instruction_in), .pc_plus_4_in(pc_plus_4_in),
        .select_pc(select_pc), .id_ex_mem_read(id_ex_mem_read), .id_ex_rt(id_ex_rt),
        .instruction_out(instruction_out), .pc_plus_4_out(pc_plus_4_out),
        .valid_out(valid_out), .pc_write(pc_write), .id_ex_bubble(id_ex_bubble),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_instr"}, instruction_out, 32'h0);
        chk({tag, "_pc4"}, pc_plus_4_out, 32'h0);
        chk({tag, "_valid"}, {31'd0, valid_out}, 32'd0);
        chk({tag, "_stall"}, {28'd0, stall_count}, 32'd0);
        chk({tag, "_flush"}, {28'd0, flush_count}, 32'd0);
        chk({tag, "_pcw"}, {31'd0, pc_write}, 32'd1);
        chk({tag, "_bubble"}, {31'd0, id_ex_bubble}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        instruction_in = 32'h0128_5020;
        pc_plus_4_in = 32'h4;
        select_pc = 1'b0;
        id_ex_mem_read = 1'b1;
        id_ex_rt = 5'd9;
        #12;
        chk_reset("reset");
        // first edge after release captures
        rst = 1'b0;
        id_ex_mem_read = 1'b0;
        step();
        chk("cap_instr", instruction_out, 32'h0128_5020);
        chk("cap_pc4", pc_plus_4_out, 32'h4);
        chk("cap_valid", {31'd0, valid_out}, 32'd1);
        // load-use on rs=8
        instruction_in = 32'h0109_5020;
        pc_plus_4_in = 32'h8;
        step();
        chk("lu_load", instruction_out, 32'h0109_5020);
        instruction_in = 32'hxxxx_xxxx;
        pc_plus_4_in = 32'hC;
        id_ex_mem_read = 1'b1;
        id_ex_rt = 5'd8;
        #1;
        chk("lu_pcw", {31'd0, pc_write}, 32'd0);
        chk("lu_bubble", {31'd0, id_ex_bubble}, 32'd1);
        step();
        chk("lu_hold_instr", instruction_out, 32'h0109_5020);
        chk("lu_hold_pc4", pc_plus_4_out, 32'h8);
        chk("lu_hold_valid", {31'd0, valid_out}, 32'd1);
        chk("lu_stall", {28'd0, stall_count}, 32'd1);
        // bubble cleared load in EX: stall lasts one cycle
        id_ex_mem_read = 1'b0;
        instruction_in = 32'h2029_0005;
        #1;
        chk("lu_release_pcw", {31'd0, pc_write}, 32'd1);
        step();
        chk("addi_load", instruction_out, 32'h2029_0005);
        chk("addi_pc4", pc_plus_4_out, 32'hC);
        chk("addi_stall", {28'd0, stall_count}, 32'd1);
        // addi writes rt=9: not a source
        id_ex_mem_read = 1'b1;
        id_ex_rt = 5'd9;
        #1;
        chk("rtns_pcw", {31'd0, pc_write}, 32'd1);
        chk("rtns_bubble", {31'd0, id_ex_bubble}, 32'd0);
        // sw reads rt=9, rs=0
        id_ex_mem_read = 1'b0;
        instruction_in = 32'hAC09_0000;
        pc_plus_4_in = 32'h10;
        step();
        chk("sw_load", instruction_out, 32'hAC09_0000);
        id_ex_mem_read = 1'b1;
        id_ex_rt = 5'd0;
        #1;
        chk("rt0_bubble", {31'd0, id_ex_bubble}, 32'd0);
        id_ex_rt = 5'd9;
        #1;
        chk("swrt_bubble", {31'd0, id_ex_bubble}, 32'd1);
        chk("swrt_pcw", {31'd0, pc_write}, 32'd0);
        // flush beats stall
        select_pc = 1'b1;
        step();
        chk("fl_instr", instruction_out, 32'h0);
        chk("fl_pc4", pc_plus_4_out, 32'h0);
        chk("fl_valid", {31'd0, valid_out}, 32'd0);
        chk("fl_flush", {28'd0, flush_count}, 32'd1);
        chk("fl_stall", {28'd0, stall_count}, 32'd1);
        chk("fl_nobubble", {31'd0, id_ex_bubble}, 32'd0);
        // saturation of stall_count
        select_pc = 1'b0;
        id_ex_mem_read = 1'b0;
        instruction_in = 32'h0109_5020;
        pc_plus_4_in = 32'h14;
        step();
        chk("sat_load", instruction_out, 32'h0109_5020);
        id_ex_mem_read = 1'b1;
        id_ex_rt = 5'd8;
        instruction_in = 32'h1111_1111;
        for (int i = 0; i < 20; i++) step();
        chk("sat_stall", {28'd0, stall_count}, 32'd15);
        chk("sat_hold", instruction_out, 32'h0109_5020);
        step();
        chk("sat_stay", {28'd0, stall_count}, 32'd15);
        // async reset mid-stall, between edges
        #3 rst = 1'b1;
        #1;
        chk_reset("areset");
        #2;
        rst = 1'b0;
        id_ex_mem_read = 1'b0;
        instruction_in = 32'h0128_5020;
        pc_plus_4_in = 32'h4;
        step();
        chk("post_instr", instruction_out, 32'h0128_5020);
        chk("post_valid", {31'd0, valid_out}, 32'd1);
        chk("post_stall", {28'd0, stall_count}, 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
